// File: rtl/dsp_failover_ctrl.sv
// dsp_failover_ctrl: confirms DSP A heartbeat loss, hands control to DSP B via req/ack, resets A, returns on B's clear request
module dsp_failover_ctrl #(
  parameter int CONFIRM_CYC = 3000,
  parameter int ACK_TIMEOUT = 30000,
  parameter int RST_PULSE   = 300,
  parameter int REARM_CYC   = 60000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iFault,
  input  logic       iBAck,
  input  logic       iClearReq,
  output logic       oBReq,
  output logic       oSelB,
  output logic       oResetA,
  output logic       oAlarm,
  output logic [7:0] oFailCnt
);
  localparam int TW = 17;
  localparam logic [2:0] S_A       = 3'd0;
  localparam logic [2:0] S_CONFIRM = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_B       = 3'd3;
  localparam logic [2:0] S_ALARM   = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d, healthy_q, healthy_d;
  logic [1:0]    ack_sync_q;
  logic [2:0]    clr_sync_q;
  logic          ack, clr_rise, rearmed;
  assign ack      = ack_sync_q[1];
  assign clr_rise = clr_sync_q[1] & ~clr_sync_q[2];
  assign rearmed  = healthy_q == TW'(REARM_CYC);
  // next state, phase timer and healthy counter; the timer is reused per state
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    healthy_d = '0;
    case (state_q)
      S_A: begin
        state_d = iFault ? S_CONFIRM : S_A;
        timer_d = '0;
      end
      S_CONFIRM: begin
        state_d = !iFault ? S_A : (timer_q == TW'(CONFIRM_CYC - 1)) ? S_REQ : S_CONFIRM;
        timer_d = (state_d == S_CONFIRM) ? timer_q + 1'b1 : '0;
      end
      S_REQ: begin
        state_d = ack ? S_B : (timer_q == TW'(ACK_TIMEOUT - 1)) ? S_ALARM : S_REQ;
        timer_d = (state_d == S_REQ) ? timer_q + 1'b1 : '0;
      end
      S_B: begin
        timer_d   = (timer_q == TW'(RST_PULSE)) ? timer_q : timer_q + 1'b1;
        healthy_d = iFault ? '0 : (oResetA || rearmed) ? healthy_q : healthy_q + 1'b1;
        if (clr_rise && !iFault && rearmed) begin
          state_d   = S_A;
          timer_d   = '0;
          healthy_d = '0;
        end
      end
      S_ALARM: state_d = S_ALARM;
      default: begin
        state_d = S_A;
        timer_d = '0;
      end
    endcase
  end
  // state, synchronisers and registered output decode
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= S_A;
      timer_q    <= '0;
      healthy_q  <= '0;
      ack_sync_q <= '0;
      clr_sync_q <= '0;
      oBReq      <= 1'b0;
      oSelB      <= 1'b0;
      oResetA    <= 1'b0;
      oAlarm     <= 1'b0;
      oFailCnt   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      healthy_q  <= healthy_d;
      ack_sync_q <= {ack_sync_q[0], iBAck};
      clr_sync_q <= {clr_sync_q[1:0], iClearReq};
      oBReq      <= state_d == S_REQ;
      oSelB      <= state_d == S_B;
      oResetA    <= state_d == S_B && timer_d < TW'(RST_PULSE);
      oAlarm     <= state_d == S_ALARM;
      oFailCnt   <= (state_q == S_REQ && state_d == S_B && oFailCnt != 8'hff) ? oFailCnt + 1'b1 : oFailCnt;
    end
  end
endmodule

// File: tb/tb_dsp_failover_ctrl.sv
// tb_dsp_failover_ctrl: directed checks of confirm, handshake, alarm, rearm and counter saturation
module tb_dsp_failover_ctrl;
  logic       iClk = 1'b0, iRst = 1'b1, iFault = 1'b0, iBAck = 1'b0, iClearReq = 1'b0;
  logic       oBReq, oSelB, oResetA, oAlarm;
  logic [7:0] oFailCnt;
  int total = 0, bad = 0;
  dsp_failover_ctrl #(.CONFIRM_CYC(8), .ACK_TIMEOUT(20), .RST_PULSE(4), .REARM_CYC(10)) dut (
    .iClk(iClk), .iRst(iRst), .iFault(iFault), .iBAck(iBAck), .iClearReq(iClearReq),
    .oBReq(oBReq), .oSelB(oSelB), .oResetA(oResetA), .oAlarm(oAlarm), .oFailCnt(oFailCnt)
  );
  always #5 iClk = ~iClk;
  task automatic step(input int n);
    repeat (n) @(negedge iClk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_outs(input string tag, input logic [3:0] exp_flags, input logic [7:0] exp_cnt);
    chk({tag, ".flags"}, {28'd0, oBReq, oSelB, oResetA, oAlarm}, {28'd0, exp_flags});
    chk({tag, ".cnt"}, {24'd0, oFailCnt}, {24'd0, exp_cnt});
  endtask
  initial begin
    step(3);
    chk_outs("reset", 4'b0000, 8'd0);
    iRst = 1'b0;
    step(1);
    iFault = 1'b1;
    step(5);
    iFault = 1'b0;
    step(1);
    chk_outs("glitch5", 4'b0000, 8'd0);
    chk("glitch5.state", {29'd0, dut.state_q}, 32'd0);
    iFault = 1'b1;
    step(8);
    iFault = 1'b0;
    step(2);
    chk_outs("glitch8", 4'b0000, 8'd0);
    iFault = 1'b1;
    step(8);
    chk_outs("confirm.pre", 4'b0000, 8'd0);
    step(1);
    chk_outs("confirm.req", 4'b1000, 8'd0);
    step(6);
    iBAck = 1'b1;
    step(2);
    chk_outs("ack.edge2", 4'b1000, 8'd0);
    step(1);
    chk_outs("ack.edge3", 4'b0110, 8'd1);
    step(3);
    chk_outs("rsta.last", 4'b0110, 8'd1);
    step(1);
    chk_outs("rsta.end", 4'b0100, 8'd1);
    iFault = 1'b0;
    step(6);
    iClearReq = 1'b1;
    step(3);
    chk_outs("clr.early", 4'b0100, 8'd1);
    step(5);
    chk_outs("clr.held", 4'b0100, 8'd1);
    iClearReq = 1'b0;
    step(3);
    iClearReq = 1'b1;
    step(2);
    chk_outs("clr.edge2", 4'b0100, 8'd1);
    step(1);
    chk_outs("clr.return", 4'b0000, 8'd1);
    chk("clr.state", {29'd0, dut.state_q}, 32'd0);
    iClearReq = 1'b0;
    iBAck = 1'b0;
    step(3);
    iFault = 1'b1;
    step(9);
    chk_outs("alarm.req", 4'b1000, 8'd1);
    step(19);
    chk_outs("alarm.pre", 4'b1000, 8'd1);
    step(1);
    chk_outs("alarm.set", 4'b0001, 8'd1);
    iBAck = 1'b1;
    iClearReq = 1'b1;
    iFault = 1'b0;
    step(6);
    chk_outs("alarm.sticky", 4'b0001, 8'd1);
    iRst = 1'b1;
    step(1);
    chk_outs("alarm.rst", 4'b0000, 8'd0);
    iBAck = 1'b0;
    iClearReq = 1'b0;
    step(2);
    iRst = 1'b0;
    step(1);
    iFault = 1'b1;
    step(9);
    chk_outs("tie.req", 4'b1000, 8'd0);
    step(17);
    iBAck = 1'b1;
    step(2);
    chk_outs("tie.pre", 4'b1000, 8'd0);
    step(1);
    chk_outs("tie.ackwins", 4'b0110, 8'd1);
    step(1);
    iRst = 1'b1;
    step(1);
    chk_outs("midrst", 4'b0000, 8'd0);
    iRst = 1'b0;
    iFault = 1'b0;
    iBAck = 1'b0;
    step(3);
    for (int i = 0; i < 300; i++) begin
      iFault = 1'b1;
      iBAck = 1'b1;
      step(10);
      chk("loop.cnt", {24'd0, oFailCnt}, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      iFault = 1'b0;
      iBAck = 1'b0;
      step(15);
      iClearReq = 1'b1;
      step(3);
      chk("loop.ret", {31'd0, oSelB}, 32'd0);
      iClearReq = 1'b0;
      step(3);
    end
    chk_outs("sat", 4'b0000, 8'd255);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
